// File: rtl/mm6532_pkg.sv
// Shared constants for the 6532 RIOT timer/PA7 control block: prescale codes,
// address bit positions and the flag-register layout.
package mm6532_pkg;

  typedef enum logic [1:0] {
    PRESCALE_1T    = 2'b00,
    PRESCALE_8T    = 2'b01,
    PRESCALE_64T   = 2'b10,
    PRESCALE_1024T = 2'b11
  } prescale_e;

  localparam int A_TIMER    = 4;
  localparam int A_IE       = 3;
  localparam int A_SEL      = 2;
  localparam int A_EDGE_IE  = 1;
  localparam int A_EDGE_POL = 0;
  localparam int A_FLAG_RD  = 0;

  localparam int FLAG_TIMER_BIT = 7;
  localparam int FLAG_PA7_BIT   = 6;

  function automatic logic [7:0] flag_byte(input logic timer_flag, input logic pa7_flag);
    logic [7:0] v;
    v = 8'h00;
    v[FLAG_TIMER_BIT] = timer_flag;
    v[FLAG_PA7_BIT]   = pa7_flag;
    return v;
  endfunction

endpackage

// File: rtl/riot_timer_ctrl_pa7_edge_detect.sv
// PA7 synchroniser, history flop and polarity-selected single-cycle edge pulse.
module pa7_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic i_pa7,
  input  logic i_edge_pos,
  output logic o_edge
);

  // Bits [SYNC_STAGES-1:0] are the synchroniser, the top bit is the history flop.
  logic [SYNC_STAGES:0] r_chain;
  logic [SYNC_STAGES:0] r_vld;
  logic                 w_sync;
  logic                 w_hist;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_chain <= '0;
      r_vld   <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-1:0], i_pa7};
      r_vld   <= {r_vld[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_sync = r_chain[SYNC_STAGES-1];
  assign w_hist = r_chain[SYNC_STAGES];

  // Edges are ignored until the history flop holds a post-reset sample, so a
  // level already present at reset release never looks like a transition.
  assign o_edge = r_vld[SYNC_STAGES] & (w_sync ^ w_hist) & (i_edge_pos ? w_sync : w_hist);

endmodule

// File: rtl/riot_timer_ctrl.sv
// RIOT timer/PA7 register decode: timer load strobe, interrupt flags and enables,
// registered read-back, and the combined active-low interrupt request.
module riot_timer_ctrl
  import mm6532_pkg::*;
#(
  parameter int PA7_SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CS,
  input  logic       RW,
  input  logic [4:0] A,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       PA7,
  output logic       TIM_WE,
  output logic [1:0] TIM_PRESCALE,
  output logic [7:0] TIM_IN,
  input  logic [7:0] TIM_OUT,
  input  logic       TIM_INTERRUPT,
  output logic       IRQ_N
);

  logic       r_timer_flag;
  logic       r_pa7_flag;
  logic       r_timer_ie;
  logic       r_pa7_ie;
  logic       r_edge_pos;
  logic [7:0] r_do;

  logic w_acc;
  logic w_wr;
  logic w_rd;
  logic w_tim_wr;
  logic w_edge_wr;
  logic w_intim_rd;
  logic w_flag_rd;
  logic w_pa7_edge;

  // Reset gates every access so an in-flight cycle has no side effects.
  assign w_acc      = CS & ~RES;
  assign w_wr       = w_acc & ~RW & A[A_SEL];
  assign w_rd       = w_acc &  RW & A[A_SEL];
  assign w_tim_wr   = w_wr &  A[A_TIMER];
  assign w_edge_wr  = w_wr & ~A[A_TIMER];
  assign w_intim_rd = w_rd & ~A[A_FLAG_RD];
  assign w_flag_rd  = w_rd &  A[A_FLAG_RD];

  assign TIM_WE       = w_tim_wr;
  assign TIM_IN       = w_tim_wr ? DI : 8'h00;
  assign TIM_PRESCALE = w_tim_wr ? A[1:0] : 2'b00;

  pa7_edge_detect #(
    .SYNC_STAGES (PA7_SYNC_STAGES)
  ) u_pa7_edge (
    .clk        (CLK),
    .srst       (RES),
    .i_pa7      (PA7),
    .i_edge_pos (r_edge_pos),
    .o_edge     (w_pa7_edge)
  );

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_timer_flag <= 1'b0;
      r_pa7_flag   <= 1'b0;
      r_timer_ie   <= 1'b0;
      r_pa7_ie     <= 1'b0;
      r_edge_pos   <= 1'b0;
      r_do         <= 8'h00;
    end else begin
      // Set-priority flags: an event in the same cycle as a clear wins.
      if (TIM_INTERRUPT)
        r_timer_flag <= 1'b1;
      else if (w_tim_wr | w_intim_rd)
        r_timer_flag <= 1'b0;

      if (w_tim_wr | w_intim_rd)
        r_timer_ie <= A[A_IE];

      if (w_pa7_edge)
        r_pa7_flag <= 1'b1;
      else if (w_flag_rd)
        r_pa7_flag <= 1'b0;

      if (w_edge_wr) begin
        r_edge_pos <= A[A_EDGE_POL];
        r_pa7_ie   <= A[A_EDGE_IE];
      end

      if (w_flag_rd)
        r_do <= flag_byte(r_timer_flag, r_pa7_flag);
      else if (w_intim_rd)
        r_do <= TIM_OUT;
      else
        r_do <= 8'h00;
    end
  end

  assign DO    = r_do;
  assign IRQ_N = ~(~RES & ((r_timer_flag & r_timer_ie) | (r_pa7_flag & r_pa7_ie)));

endmodule

// File: doc/riot_timer_ctrl.md
RIOT_TIMER_CTRL -- requirements
Module: riot_timer_ctrl

Interface
REQ-001 Parameter: PA7_SYNC_STAGES, default 2, number of PA7 synchroniser flops (min 1).
REQ-002 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-003 RES  in  1  reset; synchronous and active-high.
REQ-004 CS  in  1  chip select; each cycle with CS=1 is one bus access.
REQ-005 RW  in  1  1 = read, 0 = write.
REQ-006 A  in  5  register address.
REQ-007 DI  in  8  write data.
REQ-008 DO  out  8  registered read data.
REQ-009 PA7  in  1  asynchronous edge-detect input.
REQ-010 TIM_WE  out  1  timer load strobe to interval timer.
REQ-011 TIM_PRESCALE  out  2  prescale select: 00=1T, 01=8T, 10=64T, 11=1024T.
REQ-012 TIM_IN  out  8  timer load value.
REQ-013 TIM_OUT  in  8  current timer count.
REQ-014 TIM_INTERRUPT  in  1  one-cycle timer expiry pulse.
REQ-015 IRQ_N  out  1  active-low interrupt request.

Function
REQ-016 Timer write: CS=1, RW=0, A[4]=1, A[2]=1 -> same-cycle TIM_WE=1, TIM_IN=DI, TIM_PRESCALE=A[1:0]; timer_ie <= A[3]; timer_flag cleared.
REQ-017 TIM_WE, TIM_IN and TIM_PRESCALE are combinational decodes; TIM_WE=0 and TIM_IN, TIM_PRESCALE = 0 outside a timer write.
REQ-018 Edge-control write: CS=1, RW=0, A[4]=0, A[2]=1 -> edge_pos <= A[0] (1=rising, 0=falling); pa7_ie <= A[1].
REQ-019 INTIM read: CS=1, RW=1, A[2]=1, A[0]=0 -> next cycle DO = TIM_OUT sampled in access cycle; timer_ie <= A[3]; timer_flag cleared.
REQ-020 Flag read: CS=1, RW=1, A[2]=1, A[0]=1 -> next cycle DO = {timer_flag, pa7_flag, 6'b0} as of access cycle; pa7_flag cleared; timer_flag unaffected.
REQ-021 Read latency exactly 1 cycle; DO = 0 the cycle after any non-read, A[2]=0 or CS=0 cycle.
REQ-022 A[2]=0 accesses (RAM/IO space) ignored entirely.
REQ-023 timer_flag set when TIM_INTERRUPT=1; set beats a same-cycle clear (read or write).
REQ-024 PA7 passes PA7_SYNC_STAGES flops, then one history flop; an edge matching edge_pos sets pa7_flag one cycle after the synchronised value changes.
REQ-025 pa7_flag set beats a same-cycle flag-read clear; DO for that read shows the pre-set value.
REQ-026 Change of edge_pos never itself generates an edge; detection uses the new polarity from the next cycle.
REQ-027 IRQ_N = ~((timer_flag & timer_ie) | (pa7_flag & pa7_ie)), combinational from registers.
REQ-028 Flags latch regardless of enable bits; enabling later asserts IRQ_N immediately.
REQ-029 Repeated CS cycles are independent accesses; each read re-applies its clear.

Reset
REQ-030 RES=1 -> timer_flag=0, pa7_flag=0, timer_ie=0, pa7_ie=0, edge_pos=0, DO=0, sync/history flops=0.
REQ-031 During RES, IRQ_N=1 and TIM_WE=0 regardless of CS.
REQ-032 After RES deasserts, a PA7 held high yields no falling-edge flag; held-high PA7 with edge_pos=1 produces no rising-edge flag until a fresh low-to-high transition.
REQ-033 RES mid-access aborts the access; no flag or enable change from that cycle.

Structure
REQ-034 Shared package mm6532_pkg holds prescale codes, address bit indices (A_TIMER=4, A_SEL=2, A_IE=3), flag bit positions (7 timer, 6 PA7).
REQ-035 One sub-module: pa7_edge_detect (synchroniser, history flop, polarity select, one-cycle edge pulse).

Verification
REQ-036 Write DI=0x05, A=0x1D -> TIM_WE pulse, TIM_PRESCALE=01, TIM_IN=0x05, timer_ie=1; TIM_INTERRUPT pulse -> IRQ_N=0 next cycle.
REQ-037 With timer_flag=1, INTIM read A=0x04 -> DO=TIM_OUT next cycle, timer_flag=0, IRQ_N=1.
REQ-038 Edge ctrl A=0x07 (rising, ie=1), PA7 0->1 -> pa7_flag=1, IRQ_N=0; flag read A=0x05 -> DO=0x40, then IRQ_N=1.
REQ-039 TIM_INTERRUPT coincident with INTIM read -> timer_flag stays 1; following flag read DO=0x80.
REQ-040 Falling-edge mode, PA7 high across reset release -> no flag; PA7 1->0 -> flag set, DO=0x40 on flag read.
REQ-041 RES asserted during timer write -> TIM_WE=0, timer_ie stays 0, DO=0.
